// File: rtl/tx_tlp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_tlp_arbiter
//  Description : Credit-aware round-robin arbiter that merges posted,
//                non-posted and completion TLPs onto a single registered
//                output stage toward the data link layer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_tlp_arbiter #(
    parameter int TLP_W     = 1024,
    parameter int CRED_W    = 8,
    parameter int INIT_CRED = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [TLP_W-1:0] p_tlp_i,
    input  logic             p_valid_i,
    output logic             p_ready_o,
    input  logic [TLP_W-1:0] np_tlp_i,
    input  logic             np_valid_i,
    output logic             np_ready_o,
    input  logic [TLP_W-1:0] cpl_tlp_i,
    input  logic             cpl_valid_i,
    output logic             cpl_ready_o,
    input  logic [2:0]       fc_ret_i,
    output logic [TLP_W-1:0] tlp_out,
    output logic             tlp_out_valid,
    input  logic             tlp_in_ready,
    output logic [1:0]       tlp_out_class,
    output logic             credit_err_o
);

    localparam logic [CRED_W-1:0] c_init_cred = CRED_W'(INIT_CRED);
    localparam logic [1:0]        c_cls_p     = 2'd0;
    localparam logic [1:0]        c_cls_np    = 2'd1;
    localparam logic [1:0]        c_cls_cpl   = 2'd2;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_last;
    logic [TLP_W-1:0] r_tlp;
    logic [1:0]       r_class;
    logic             r_credit_err;

    logic [2:0]       w_valid;
    logic [2:0]       w_elig;
    logic [2:0]       w_grant;
    logic [2:0]       w_cred_err;
    logic             w_load_en;
    logic             w_any_grant;
    logic [1:0]       w_grant_idx;
    logic [1:0]       w_ord [3];
    logic [TLP_W-1:0] w_tlp_sel;

    assign w_valid   = {cpl_valid_i, np_valid_i, p_valid_i};
    assign w_load_en = (r_state == ST_EMPTY) || tlp_in_ready;

    // Per-class credit counters: grant consumes, return restores, saturating at INIT_CRED
    for (genvar k = 0; k < 3; k++) begin : g_cred
        logic [CRED_W-1:0] r_cnt;

        // Credit counter update; grant and return in the same cycle cancel out
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= c_init_cred;
            end else if (w_grant[k] && !fc_ret_i[k]) begin
                r_cnt <= r_cnt - CRED_W'(1);
            end else if (!w_grant[k] && fc_ret_i[k] && (r_cnt != c_init_cred)) begin
                r_cnt <= r_cnt + CRED_W'(1);
            end
        end

        // Eligibility uses the current count, so a return into an empty counter helps next cycle
        assign w_elig[k]     = w_valid[k] && (r_cnt != '0);
        assign w_cred_err[k] = fc_ret_i[k] && !w_grant[k] && (r_cnt == c_init_cred);
    end

    // Scan order starts just after the last-granted class
    always_comb begin
        w_ord = '{c_cls_p, c_cls_np, c_cls_cpl};
        case (r_last)
            c_cls_p:  w_ord = '{c_cls_np, c_cls_cpl, c_cls_p};
            c_cls_np: w_ord = '{c_cls_cpl, c_cls_p, c_cls_np};
            default:  w_ord = '{c_cls_p, c_cls_np, c_cls_cpl};
        endcase
    end

    // Pick the first eligible class in round-robin order when the output stage can load
    always_comb begin
        w_any_grant = 1'b0;
        w_grant_idx = r_last;
        if (w_load_en) begin
            for (int i = 0; i < 3; i++) begin
                if (!w_any_grant && w_elig[w_ord[i]]) begin
                    w_any_grant = 1'b1;
                    w_grant_idx = w_ord[i];
                end
            end
        end
        w_grant = w_any_grant ? 3'(3'b001 << w_grant_idx) : 3'b000;
    end

    // Data mux for the granted class
    always_comb begin
        w_tlp_sel = p_tlp_i;
        case (w_grant_idx)
            c_cls_np:  w_tlp_sel = np_tlp_i;
            c_cls_cpl: w_tlp_sel = cpl_tlp_i;
            default:   w_tlp_sel = p_tlp_i;
        endcase
    end

    // Output stage next-state: fill on grant, drain when accepted with nothing new
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_any_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (tlp_in_ready) w_state_nxt = w_any_grant ? ST_FULL : ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output stage state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output payload, class and round-robin pointer captured on grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tlp   <= '0;
            r_class <= c_cls_p;
            r_last  <= c_cls_cpl;
        end else if (w_any_grant) begin
            r_tlp   <= w_tlp_sel;
            r_class <= w_grant_idx;
            r_last  <= w_grant_idx;
        end
    end

    // Sticky flag for a credit returned into a full counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credit_err <= 1'b0;
        end else if (|w_cred_err) begin
            r_credit_err <= 1'b1;
        end
    end

    assign p_ready_o     = w_grant[0];
    assign np_ready_o    = w_grant[1];
    assign cpl_ready_o   = w_grant[2];
    assign tlp_out       = r_tlp;
    assign tlp_out_valid = (r_state == ST_FULL);
    assign tlp_out_class = r_class;
    assign credit_err_o  = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_tx_tlp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_tlp_arbiter
//  Description : Self-checking bench for tx_tlp_arbiter: directed scenarios
//                with literal expectations, then randomized traffic against
//                a queue-free behavioural model of credits and round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_tlp_arbiter;

    localparam int TLP_W     = 64;
    localparam int CRED_W    = 8;
    localparam int INIT_CRED = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [TLP_W-1:0] src_tlp [3];
    logic [2:0]       src_valid;
    logic             p_ready_o, np_ready_o, cpl_ready_o;
    logic [2:0]       fc_ret;
    logic [TLP_W-1:0] tlp_out;
    logic             tlp_out_valid;
    logic             dl_ready;
    logic [1:0]       tlp_out_class;
    logic             credit_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int               m_cred [3];
    int               m_last;
    bit               m_full;
    logic [TLP_W-1:0] m_data;
    int               m_class;
    bit               m_err;
    int               m_g;      // class granted in the current cycle, -1 if none
    bit               m_load;

    always #5 clk = ~clk;

    tx_tlp_arbiter #(
        .TLP_W     (TLP_W),
        .CRED_W    (CRED_W),
        .INIT_CRED (INIT_CRED)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .p_tlp_i       (src_tlp[0]),
        .p_valid_i     (src_valid[0]),
        .p_ready_o     (p_ready_o),
        .np_tlp_i      (src_tlp[1]),
        .np_valid_i    (src_valid[1]),
        .np_ready_o    (np_ready_o),
        .cpl_tlp_i     (src_tlp[2]),
        .cpl_valid_i   (src_valid[2]),
        .cpl_ready_o   (cpl_ready_o),
        .fc_ret_i      (fc_ret),
        .tlp_out       (tlp_out),
        .tlp_out_valid (tlp_out_valid),
        .tlp_in_ready  (dl_ready),
        .tlp_out_class (tlp_out_class),
        .credit_err_o  (credit_err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_cred[k] = INIT_CRED;
        m_last  = 2;
        m_full  = 0;
        m_data  = '0;
        m_class = 0;
        m_err   = 0;
        m_g     = -1;
    endtask

    // Called just after the negedge once inputs are driven: predict and compare
    task automatic sample();
        logic [2:0] exp_rdy;
        #1;
        m_load = !m_full || dl_ready;
        m_g    = -1;
        if (m_load) begin
            for (int i = 1; i <= 3; i++) begin
                int k;
                k = (m_last + i) % 3;
                if (m_g < 0 && src_valid[k] && m_cred[k] > 0) m_g = k;
            end
        end
        exp_rdy = (m_g >= 0) ? 3'(3'b001 << m_g) : 3'b000;
        check("ready", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, {61'd0, exp_rdy});
        check("out_valid", {63'd0, tlp_out_valid}, {63'd0, m_full});
        if (m_full) begin
            check("out_data", tlp_out, m_data);
            check("out_class", {62'd0, tlp_out_class}, 64'(m_class));
        end
        check("credit_err", {63'd0, credit_err_o}, {63'd0, m_err});
    endtask

    // Clock edge: apply the spec's update rules to the model
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            bit dec, inc;
            dec = (m_g == k);
            inc = fc_ret[k];
            if (dec && !inc) m_cred[k]--;
            else if (inc && !dec) begin
                if (m_cred[k] == INIT_CRED) m_err = 1;
                else m_cred[k]++;
            end
        end
        if (m_g >= 0) begin
            m_full  = 1;
            m_data  = src_tlp[m_g];
            m_class = m_g;
            m_last  = m_g;
        end else if (m_load) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    // Accepted source presents its next TLP (still valid)
    task automatic next_data();
        if (m_g >= 0) src_tlp[m_g] = {$urandom, $urandom};
    endtask

    task automatic drive_random();
        for (int k = 0; k < 3; k++) begin
            if (m_g == k || !src_valid[k]) begin
                src_valid[k] = ($urandom_range(3) != 0);
                src_tlp[k]   = {$urandom, $urandom};
            end
            fc_ret[k] = (m_cred[k] < INIT_CRED && $urandom_range(1) == 1) ||
                        ($urandom_range(63) == 0);
        end
        dl_ready = ($urandom_range(3) != 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        src_valid = 3'b000;
        fc_ret    = 3'b000;
        dl_ready  = 1'b1;
        for (int k = 0; k < 3; k++) src_tlp[k] = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_valid", {63'd0, tlp_out_valid}, 64'd0);
        check("rst_class", {62'd0, tlp_out_class}, 64'd0);
        check("rst_data", tlp_out, 64'd0);
        check("rst_err", {63'd0, credit_err_o}, 64'd0);

        // Round-robin with all classes valid, then credit exhaustion
        reset_n    = 1'b1;
        src_valid  = 3'b111;
        src_tlp[0] = 64'hAAAA_0000_0000_0001;
        src_tlp[1] = 64'hBBBB_0000_0000_0002;
        src_tlp[2] = 64'hCCCC_0000_0000_0003;
        sample(); check("rr_first", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b001);
        advance(); next_data();
        sample(); check("rr_np", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b010);
        check("first_out", tlp_out, 64'hAAAA_0000_0000_0001);
        check("first_valid", {63'd0, tlp_out_valid}, 64'd1);
        advance(); next_data();
        sample(); check("rr_cpl", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b100);
        check("cls_np", {62'd0, tlp_out_class}, 64'd1);
        advance(); next_data();
        repeat (3) begin sample(); advance(); next_data(); end
        // All credits spent: nothing granted while valid; stage drains
        sample(); check("no_cred", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b000);
        advance();
        // Return into an empty P counter: still ineligible this cycle
        fc_ret = 3'b001;
        sample(); check("ret_zero", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b000);
        check("drained", {63'd0, tlp_out_valid}, 64'd0);
        advance();
        fc_ret = 3'b000;
        sample(); check("p_after_ret", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b001);
        advance(); next_data();

        // Stall: output holds, no ready; an NP credit comes back meanwhile
        dl_ready = 1'b0;
        fc_ret   = 3'b010;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("stall_rdy", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b000);
            check("stall_cls", {62'd0, tlp_out_class}, 64'd0);
            advance();
            fc_ret = 3'b000;
        end
        dl_ready = 1'b1;
        sample(); check("unstall_np", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b010);
        advance();

        // Asynchronous reset while FULL
        sample();
        reset_n = 1'b0;
        #1;
        check("async_rst", {63'd0, tlp_out_valid}, 64'd0);
        model_reset();
        @(negedge clk);
        reset_n   = 1'b1;
        src_valid = 3'b111;
        fc_ret    = 3'b001;
        // Grant P with a P return in the same cycle: count stays at INIT_CRED
        sample(); check("post_rst_p", {61'd0, cpl_ready_o, np_ready_o, p_ready_o}, 64'b001);
        advance();
        src_valid = 3'b000;
        sample(); advance();
        fc_ret = 3'b000;
        sample(); check("err_set", {63'd0, credit_err_o}, 64'd1);
        advance();

        // Randomized traffic against the model
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
